// File: rtl/dma_ch_sched.sv
// dma_ch_sched: channel scheduler for the dma_axi64 engine.
// Arbitrates N_CH channel burst requests onto the single shared AXI64 engine
// with priority round-robin and starvation promotion of low-priority channels.
// Peripheral-flow channels are gated on periph_req; periph_clr pulses at the
// end of a peripheral block.
//
// Ports:
//   clk          core clock
//   reset        asynchronous, active-low reset
//   ch_en        per-channel enable
//   ch_req       per-channel burst pending
//   ch_prio      per-channel high priority
//   ch_periph_en per-channel peripheral flow control
//   periph_req   per-channel peripheral request level
//   eng_ready    engine can accept a new burst (sampled only while idle)
//   ch_done      1-cycle pulse: granted burst complete
//   ch_last      qualifies ch_done: last burst of the peripheral block
//   gnt          one-hot grant, held for the whole burst
//   gnt_valid    gnt/gnt_id valid
//   gnt_id       binary index of gnt
//   periph_clr   1-cycle clear pulse to the peripheral
//   idle         no grant active and no eligible channel (registered)
module dma_ch_sched #(
  parameter int N_CH       = 8,
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 3,
  parameter int ID_W       = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] ch_en,
  input  logic [N_CH-1:0] ch_req,
  input  logic [N_CH-1:0] ch_prio,
  input  logic [N_CH-1:0] ch_periph_en,
  input  logic [N_CH-1:0] periph_req,
  input  logic            eng_ready,
  input  logic            ch_done,
  input  logic            ch_last,
  output logic [N_CH-1:0] gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic [N_CH-1:0] periph_clr,
  output logic            idle
);

  localparam int unsigned      N   = N_CH;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] rr_ptr, rr_n;
  logic [N_CH-1:0] eligible, high;
  logic [N_CH-1:0] gnt_n, clr_n;
  logic            gnt_valid_n, idle_n, grant_now;
  logic [ID_W-1:0] gnt_id_n, win, hi_idx, lo_idx, pos_i;
  logic            hi_found, lo_found;
  int unsigned     pos;

  // Per-channel eligibility, effective priority and starvation counter.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;

    assign eligible[g] = ch_en[g] & ch_req[g] & (~ch_periph_en[g] | periph_req[g]);
    assign high[g]     = ch_prio[g] | (cnt == LIM);

    // Only channels that are low by their own priority age; a promoted
    // channel that still loses stays saturated at the limit.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (!ch_en[g]) begin
        cnt <= '0;
      end else if (grant_now) begin
        if (win == ID_W'(g))
          cnt <= '0;
        else if (eligible[g] && !ch_prio[g] && cnt != LIM)
          cnt <= cnt + 1'b1;
      end
    end
  end

  // First eligible high, else first eligible low, scanning from rr_ptr with wrap.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    pos      = 0;
    pos_i    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos   = (32'(rr_ptr) + k) % N;
      pos_i = ID_W'(pos);
      if (eligible[pos_i] && high[pos_i] && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = pos_i;
      end
      if (eligible[pos_i] && !high[pos_i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = pos_i;
      end
    end
    win = hi_found ? hi_idx : lo_idx;
  end

  assign grant_now = (state == S_IDLE) && eng_ready && (|eligible);

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    gnt_valid_n = gnt_valid;
    gnt_id_n    = gnt_id;
    rr_n        = rr_ptr;
    clr_n       = '0;
    idle_n      = (state == S_IDLE) && !(|eligible);
    case (state)
      S_IDLE: begin
        if (grant_now) begin
          state_n      = S_GRANT;
          gnt_n        = '0;
          gnt_n[win]   = 1'b1;
          gnt_valid_n  = 1'b1;
          gnt_id_n     = win;
        end
      end
      S_GRANT: begin
        if (ch_done) begin
          state_n     = S_IDLE;
          gnt_n       = '0;
          gnt_valid_n = 1'b0;
          rr_n        = (gnt_id == ID_W'(N_CH - 1)) ? '0 : gnt_id + 1'b1;
          if (ch_last && ch_periph_en[gnt_id])
            clr_n[gnt_id] = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      gnt_id     <= '0;
      rr_ptr     <= '0;
      periph_clr <= '0;
      idle       <= 1'b1;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      gnt_valid  <= gnt_valid_n;
      gnt_id     <= gnt_id_n;
      rr_ptr     <= rr_n;
      periph_clr <= clr_n;
      idle       <= idle_n;
    end
  end

endmodule

// File: tb/tb_dma_ch_sched.sv
`timescale 1ns/1ps
module tb_dma_ch_sched;

  localparam int N_CH = 8;
  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] ch_en, ch_req, ch_prio, ch_periph_en, periph_req;
  logic            eng_ready, ch_done, ch_last;
  logic [N_CH-1:0] gnt, periph_clr;
  logic            gnt_valid, idle;
  logic [ID_W-1:0] gnt_id;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  logic prev_gv = 1'b0;

  always #5 clk = ~clk;

  dma_ch_sched #(.N_CH(N_CH), .STARVE_LIM(4), .CNT_W(3), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .ch_req(ch_req), .ch_prio(ch_prio),
    .ch_periph_en(ch_periph_en), .periph_req(periph_req), .eng_ready(eng_ready),
    .ch_done(ch_done), .ch_last(ch_last), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .periph_clr(periph_clr), .idle(idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every new grant is matched against the next expected channel.
  always @(negedge clk) begin
    if (gnt_valid && !prev_gv) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_gnt", exp_q.size(), 1);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("sb_gnt_id", gnt_id, e);
        chk("sb_gnt_onehot", gnt, 32'd1 << e);
      end
    end
    prev_gv = gnt_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0;
    ch_en = '0; ch_req = '0; ch_prio = '0; ch_periph_en = '0; periph_req = '0;
    eng_ready = 1'b1; ch_done = 1'b0; ch_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (!gnt_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("gnt_wait", gnt_valid, 1'b1);
  endtask

  task automatic end_burst(input int len, input logic last, input logic [N_CH-1:0] exp_clr);
    repeat (len) @(posedge clk);
    #1 ch_done = 1'b1; ch_last = last;
    @(posedge clk); #1;
    ch_done = 1'b0; ch_last = 1'b0;
    chk("gv_fall", gnt_valid, 1'b0);
    chk("clr_pulse", periph_clr, exp_clr);
    @(posedge clk); #1;
    chk("clr_end", periph_clr, '0);
  endtask

  task automatic run_seq(input int n, input int len);
    for (int i = 0; i < n; i++) begin
      wait_gnt();
      if (i == n - 1) ch_req = '0;
      end_burst(len, 1'b0, '0);
    end
    chk("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    // 1: reset state held with all channels requesting
    reset = 1'b0;
    ch_en = '1; ch_req = '1; ch_prio = '0; ch_periph_en = '0; periph_req = '0;
    eng_ready = 1'b1; ch_done = 1'b0; ch_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, '0);
    chk("rst_gv", gnt_valid, 1'b0);
    chk("rst_gnt_id", gnt_id, '0);
    chk("rst_clr", periph_clr, '0);
    chk("rst_idle", idle, 1'b1);
    exp_q.push_back(0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_first_gnt", gnt, 8'h01);
    run_seq(1, 2);

    // 2: round robin over channels 0,1,3
    do_reset();
    ch_en = 8'h0B; ch_req = 8'h0B;
    foreach (exp_q[i]) ; // queue already drained
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    end
    run_seq(6, 4);

    // 3: priority with starvation promotion; ch0 counter restarts after its win
    do_reset();
    ch_en = 8'h11; ch_req = 8'h11; ch_prio = 8'h10;
    for (int r = 0; r < 2; r++) begin
      repeat (4) exp_q.push_back(4);
      exp_q.push_back(0);
    end
    run_seq(10, 2);

    // 4: peripheral flow control
    do_reset();
    ch_en = 8'h04; ch_req = 8'h04; ch_periph_en = 8'h04; periph_req = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    chk("periph_gated_gv", gnt_valid, 1'b0);
    chk("periph_gated_idle", idle, 1'b1);
    exp_q.push_back(2);
    exp_q.push_back(2);
    periph_req = 8'h04;
    wait_gnt();
    chk("periph_gnt", gnt, 8'h04);
    end_burst(3, 1'b1, 8'h04);
    wait_gnt();
    ch_req = '0;
    end_burst(3, 1'b0, '0);
    chk("sb_drain", exp_q.size(), 0);

    // 5a: ch_done while idle is ignored
    do_reset();
    ch_en = '1; ch_periph_en = '1;
    @(posedge clk); #1;
    ch_done = 1'b1; ch_last = 1'b1;
    @(posedge clk); #1;
    ch_done = 1'b0; ch_last = 1'b0;
    chk("idle_done_gv", gnt_valid, 1'b0);
    chk("idle_done_clr", periph_clr, '0);
    chk("idle_done_idle", idle, 1'b1);

    // 5b: granted channel disabled mid-burst keeps its grant
    ch_en = 8'h20; ch_req = 8'h20; ch_periph_en = 8'h20; periph_req = 8'h20;
    exp_q.push_back(5);
    wait_gnt();
    ch_en = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("drop_en_gnt", gnt, 8'h20);
    chk("drop_en_gv", gnt_valid, 1'b1);
    ch_req = '0;
    end_burst(1, 1'b0, '0);

    // 5c: reset mid-grant drops outputs at once and restarts rr from 0
    ch_en = 8'h06; ch_req = 8'h06; ch_periph_en = '0;
    exp_q.push_back(1);
    wait_gnt();
    end_burst(2, 1'b0, '0);
    exp_q.push_back(2);
    wait_gnt();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async_rst_gv", gnt_valid, 1'b0);
    chk("async_rst_gnt", gnt, '0);
    chk("async_rst_clr", periph_clr, '0);
    exp_q.push_back(1);
    @(posedge clk); #1;
    reset = 1'b1;
    run_seq(1, 2);

    // 6: engine not ready blocks all grants
    do_reset();
    eng_ready = 1'b0; ch_en = '1; ch_req = '1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("eng_busy_gv", gnt_valid, 1'b0);
    end
    exp_q.push_back(0);
    eng_ready = 1'b1;
    @(posedge clk); #1;
    chk("eng_ready_gnt", gnt, 8'h01);
    run_seq(1, 2);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
